// File: rtl/csr_neighbor_fetcher.sv
// csr_neighbor_fetcher: expands one vertex of a CSR graph. It reads the start/end
// row pointers, then streams the neighbor words two per cycle over edge ports A/B.
// It hides the fixed memory read latency with private tag shift registers.
module csr_neighbor_fetcher #(
  parameter int PROC_BITS = 4,
  parameter int PROC_ID   = 0,
  parameter int LATENCY   = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [31:0]            vertex_in,
  input  logic                   vertex_valid_in,
  output logic                   ready_out,
  output logic [32+PROC_BITS-1:0] idx_addr,
  output logic                   idx_validin,
  input  logic [31:0]            rowidx_in,
  output logic [32+PROC_BITS-1:0] data_addra,
  output logic [32+PROC_BITS-1:0] data_addrb,
  output logic                   data_validina,
  output logic                   data_validinb,
  input  logic [31:0]            data_ina,
  input  logic [31:0]            data_inb,
  output logic [31:0]            nbr0_out,
  output logic [31:0]            nbr1_out,
  output logic                   nbr0_valid_out,
  output logic                   nbr1_valid_out,
  output logic                   done_out,
  output logic [31:0]            degree_out,
  output logic                   err_out
);

  localparam logic [PROC_BITS-1:0] PID = PROC_BITS'(PROC_ID);
  // All tag stages except the last; those bits still owe a future return.
  localparam logic [LATENCY-1:0] HOLD_MASK = ~(LATENCY'(1) << (LATENCY - 1));

  typedef enum logic [2:0] {
    S_IDLE, S_PTR0, S_PTR1, S_PWAIT, S_EDGE, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_next;

  logic [31:0] vertex_q, start_q, end_q, cur_q, degree_q;
  logic        err_q, have_start;
  logic [LATENCY-1:0] idx_pipe, a_pipe, b_pipe;

  logic        idx_issue, a_issue, b_issue;
  logic        idx_ret, a_ret, b_ret;
  logic [31:0] idx_index;
  logic        b_in_range, edge_last, drain_busy, live;

  // Issue decisions, tag returns and range compares (33-bit to avoid wrap on cur).
  always_comb begin
    idx_issue  = (state == S_PTR0) || (state == S_PTR1);
    idx_index  = (state == S_PTR1) ? vertex_q + 32'd1 : vertex_q;
    b_in_range = ({1'b0, cur_q} + 33'd1) < {1'b0, end_q};
    edge_last  = ({1'b0, cur_q} + 33'd2) >= {1'b0, end_q};
    a_issue    = (state == S_EDGE);
    b_issue    = (state == S_EDGE) && b_in_range;
    idx_ret    = idx_pipe[LATENCY-1];
    a_ret      = a_pipe[LATENCY-1];
    b_ret      = b_pipe[LATENCY-1];
    drain_busy = |((a_pipe | b_pipe) & HOLD_MASK);
    live       = !rst_in;
  end

  // Next-state logic; empty and inverted ranges pass through DRAIN so done lands one cycle later.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (vertex_valid_in) state_next = S_PTR0;
      S_PTR0:  state_next = S_PTR1;
      S_PTR1:  state_next = S_PWAIT;
      S_PWAIT: if (idx_ret && have_start)
                 state_next = (rowidx_in > start_q) ? S_EDGE : S_DRAIN;
      S_EDGE:  if (edge_last) state_next = S_DRAIN;
      S_DRAIN: if (!drain_busy) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register, tag pipes and request bookkeeping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      idx_pipe   <= '0;
      a_pipe     <= '0;
      b_pipe     <= '0;
      vertex_q   <= '0;
      start_q    <= '0;
      end_q      <= '0;
      cur_q      <= '0;
      degree_q   <= '0;
      err_q      <= 1'b0;
      have_start <= 1'b0;
    end else begin
      state    <= state_next;
      idx_pipe <= (idx_pipe << 1) | LATENCY'(idx_issue);
      a_pipe   <= (a_pipe << 1) | LATENCY'(a_issue);
      b_pipe   <= (b_pipe << 1) | LATENCY'(b_issue);
      if (state == S_IDLE && vertex_valid_in) begin
        vertex_q   <= vertex_in;
        have_start <= 1'b0;
        err_q      <= 1'b0;
        degree_q   <= '0;
      end
      if (idx_ret) begin
        if (!have_start) begin
          start_q    <= rowidx_in;
          have_start <= 1'b1;
        end else begin
          end_q <= rowidx_in;
          cur_q <= start_q;
          if (rowidx_in >= start_q) begin
            degree_q <= rowidx_in - start_q;
            err_q    <= 1'b0;
          end else begin
            degree_q <= '0;
            err_q    <= 1'b1;
          end
        end
      end
      if (a_issue) cur_q <= cur_q + 32'd2;
    end
  end

  // Output drive; everything is forced to zero while reset is held.
  always_comb begin
    ready_out      = live && (state == S_IDLE);
    idx_validin    = live && idx_issue;
    idx_addr       = idx_validin ? {PID, idx_index} : '0;
    data_validina  = live && a_issue;
    data_validinb  = live && b_issue;
    data_addra     = data_validina ? {PID, cur_q} : '0;
    data_addrb     = data_validinb ? {PID, cur_q + 32'd1} : '0;
    nbr0_valid_out = live && a_ret;
    nbr1_valid_out = live && b_ret;
    nbr0_out       = nbr0_valid_out ? data_ina : '0;
    nbr1_out       = nbr1_valid_out ? data_inb : '0;
    done_out       = live && (state == S_DONE);
    degree_out     = done_out ? degree_q : '0;
    err_out        = done_out && err_q;
  end

endmodule

// File: tb/tb_csr_neighbor_fetcher.sv
// Self-checking bench for csr_neighbor_fetcher with a latency-2 memory model and a beat scoreboard.
module tb_csr_neighbor_fetcher;

  localparam int PB  = 4;
  localparam int LAT = 2;
  localparam int AW  = 32 + PB;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [31:0]   vertex_in = '0;
  logic          vertex_valid_in = 1'b0;
  logic          ready_out;
  logic [AW-1:0] idx_addr, data_addra, data_addrb;
  logic          idx_validin, data_validina, data_validinb;
  logic [31:0]   rowidx_in, data_ina, data_inb;
  logic [31:0]   nbr0_out, nbr1_out, degree_out;
  logic          nbr0_valid_out, nbr1_valid_out, done_out, err_out;

  csr_neighbor_fetcher #(.PROC_BITS(PB), .PROC_ID(5), .LATENCY(LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .vertex_in(vertex_in), .vertex_valid_in(vertex_valid_in), .ready_out(ready_out),
    .idx_addr(idx_addr), .idx_validin(idx_validin), .rowidx_in(rowidx_in),
    .data_addra(data_addra), .data_addrb(data_addrb),
    .data_validina(data_validina), .data_validinb(data_validinb),
    .data_ina(data_ina), .data_inb(data_inb),
    .nbr0_out(nbr0_out), .nbr1_out(nbr1_out),
    .nbr0_valid_out(nbr0_valid_out), .nbr1_valid_out(nbr1_valid_out),
    .done_out(done_out), .degree_out(degree_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int idx_strobes = 0;
  int a_strobes = 0;
  int b_strobes = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Memory model: row pointers and edge words (edge i holds 10+i), LAT-cycle read pipes.
  logic [31:0] rowmem [8];
  logic [31:0] idx_d [LAT];
  logic [31:0] a_d [LAT];
  logic [31:0] b_d [LAT];

  function automatic logic [31:0] row_word(input logic [31:0] i);
    return (i < 32'd8) ? rowmem[i[2:0]] : 32'd0;
  endfunction

  assign rowidx_in = idx_d[LAT-1];
  assign data_ina  = a_d[LAT-1];
  assign data_inb  = b_d[LAT-1];

  always @(posedge clk_in) begin
    idx_d[0] <= row_word(idx_addr[31:0]);
    a_d[0]   <= 32'd10 + data_addra[31:0];
    b_d[0]   <= 32'd10 + data_addrb[31:0];
    for (int i = 1; i < LAT; i++) begin
      idx_d[i] <= idx_d[i-1];
      a_d[i]   <= a_d[i-1];
      b_d[i]   <= b_d[i-1];
    end
    if (idx_validin) begin
      idx_strobes++;
      total++;
      if (idx_addr[AW-1:32] !== 4'd5) begin
        bad++;
        $display("[TB] FAIL idx_proc_id got=%0d want=5", idx_addr[AW-1:32]);
      end
    end
    if (data_validina) begin
      a_strobes++;
      total++;
      if (data_addra[AW-1:32] !== 4'd5) begin
        bad++;
        $display("[TB] FAIL a_proc_id got=%0d want=5", data_addra[AW-1:32]);
      end
    end
    if (data_validinb) begin
      b_strobes++;
      total++;
      if (data_validina !== 1'b1 || data_addrb[AW-1:32] !== 4'd5) begin
        bad++;
        $display("[TB] FAIL b_strobe a_valid=%0b proc=%0d want a_valid=1 proc=5",
                 data_validina, data_addrb[AW-1:32]);
      end
    end
  end

  // Scoreboard: expected beats pushed when a request is issued, popped on each lane beat.
  typedef struct {
    logic        has1;
    logic [31:0] n0;
    logic [31:0] n1;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cycles[$];

  always @(negedge clk_in) begin
    if (nbr0_valid_out || nbr1_valid_out) begin
      beat_t e;
      beat_cycles.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL stray_beat got v0=%0b v1=%0b n0=%0d want no beat",
                 nbr0_valid_out, nbr1_valid_out, nbr0_out);
      end else begin
        e = exp_q.pop_front();
        if (nbr0_valid_out !== 1'b1 || nbr1_valid_out !== e.has1 || nbr0_out !== e.n0 ||
            (e.has1 && nbr1_out !== e.n1) || done_out !== 1'b0) begin
          bad++;
          $display("[TB] FAIL beat got v=%0b%0b n0=%0d n1=%0d done=%0b want v=1%0b n0=%0d n1=%0d done=0",
                   nbr0_valid_out, nbr1_valid_out, nbr0_out, nbr1_out, done_out,
                   e.has1, e.n0, e.n1);
        end
      end
    end
  end

  task automatic push_expected(input int s, input int e);
    for (int i = s; i < e; i += 2) begin
      beat_t b;
      b.has1 = (i + 1 < e);
      b.n0   = 32'(10 + i);
      b.n1   = b.has1 ? 32'(11 + i) : 32'd0;
      exp_q.push_back(b);
    end
  endtask

  // Drives one request at a negedge where ready_out is high; returns the accept cycle.
  task automatic send_request(input logic [31:0] v, output int t_acc, output bit ok);
    ok = 1'b0;
    t_acc = 0;
    for (int i = 0; i < 50; i++) begin
      if (ready_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    if (ok) begin
      vertex_in = v;
      vertex_valid_in = 1'b1;
      t_acc = cyc;
      @(negedge clk_in);
      vertex_valid_in = 1'b0;
    end
  endtask

  task automatic wait_done(output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (done_out === 1'b1) begin
        t = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_rows(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] r3, input logic [31:0] r4);
    rowmem[0] = r0; rowmem[1] = r1; rowmem[2] = r2; rowmem[3] = r3; rowmem[4] = r4;
    for (int i = 5; i < 8; i++) rowmem[i] = 32'd0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    total++;
    if ({ready_out, idx_validin, data_validina, data_validinb, nbr0_valid_out, nbr1_valid_out,
         done_out, err_out, degree_out, idx_addr, data_addra} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got ready=%0b done=%0b deg=%0d want all zero",
               ready_out, done_out, degree_out);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset got=%0b want=1", ready_out);
    end
  endtask

  task automatic test_degree3();
    int t_acc, t_done;
    bit ok, ok2;
    load_rows(0, 3, 3, 8, 16);
    beat_cycles.delete();
    push_expected(0, 3);
    send_request(0, t_acc, ok);
    wait_done(t_done, ok2);
    total++;
    if (!(ok && ok2) || t_done !== t_acc + 9 || degree_out !== 32'd3 || err_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL deg3_done got ok=%0b dt=%0d deg=%0d err=%0b want ok=1 dt=9 deg=3 err=0",
               ok && ok2, t_done - t_acc, degree_out, err_out);
    end
    total++;
    if (exp_q.size() != 0 || beat_cycles.size() != 2 ||
        (beat_cycles.size() > 0 && beat_cycles[0] != t_acc + 7)) begin
      bad++;
      $display("[TB] FAIL deg3_beats got left=%0d beats=%0d want left=0 beats=2 first=T+7",
               exp_q.size(), beat_cycles.size());
    end
  endtask

  task automatic test_degree0();
    int t_acc, t_done;
    bit ok, ok2;
    beat_cycles.delete();
    send_request(1, t_acc, ok);
    wait_done(t_done, ok2);
    total++;
    if (!(ok && ok2) || t_done !== t_acc + 4 + LAT || degree_out !== 32'd0 || err_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL deg0_done got ok=%0b dt=%0d deg=%0d err=%0b want ok=1 dt=%0d deg=0 err=0",
               ok && ok2, t_done - t_acc, degree_out, err_out, 4 + LAT);
    end
    total++;
    if (beat_cycles.size() != 0) begin
      bad++;
      $display("[TB] FAIL deg0_beats got=%0d want=0", beat_cycles.size());
    end
  endtask

  task automatic test_degree5();
    int t_acc, t_done, i0, a0, b0;
    bit ok, ok2;
    beat_cycles.delete();
    push_expected(3, 8);
    i0 = idx_strobes; a0 = a_strobes; b0 = b_strobes;
    send_request(2, t_acc, ok);
    wait_done(t_done, ok2);
    total++;
    if (!(ok && ok2) || t_done !== t_acc + 10 || degree_out !== 32'd5 || err_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL deg5_done got ok=%0b dt=%0d deg=%0d err=%0b want ok=1 dt=10 deg=5 err=0",
               ok && ok2, t_done - t_acc, degree_out, err_out);
    end
    total++;
    if (exp_q.size() != 0 || beat_cycles.size() != 3 ||
        (beat_cycles.size() == 3 &&
         (beat_cycles[0] != t_acc + 7 || beat_cycles[2] != t_acc + 9))) begin
      bad++;
      $display("[TB] FAIL deg5_beats got left=%0d beats=%0d want left=0 beats=3 at T+7..T+9",
               exp_q.size(), beat_cycles.size());
    end
    total++;
    if (idx_strobes - i0 != 2 || a_strobes - a0 != 3 || b_strobes - b0 != 2) begin
      bad++;
      $display("[TB] FAIL deg5_strobes got idx=%0d a=%0d b=%0d want idx=2 a=3 b=2",
               idx_strobes - i0, a_strobes - a0, b_strobes - b0);
    end
  endtask

  task automatic test_error();
    int t_acc, t_done, a0;
    bit ok, ok2;
    load_rows(6, 4, 0, 0, 0);
    beat_cycles.delete();
    a0 = a_strobes;
    send_request(0, t_acc, ok);
    wait_done(t_done, ok2);
    total++;
    if (!(ok && ok2) || err_out !== 1'b1 || degree_out !== 32'd0) begin
      bad++;
      $display("[TB] FAIL err_done got ok=%0b err=%0b deg=%0d want ok=1 err=1 deg=0",
               ok && ok2, err_out, degree_out);
    end
    total++;
    if (a_strobes != a0 || beat_cycles.size() != 0) begin
      bad++;
      $display("[TB] FAIL err_no_edges got a=%0d beats=%0d want 0 0",
               a_strobes - a0, beat_cycles.size());
    end
  endtask

  task automatic test_reset_mid();
    int t_acc, t_done, stray;
    bit ok, ok2, seen;
    load_rows(0, 3, 3, 8, 16);
    beat_cycles.delete();
    send_request(3, t_acc, ok);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (data_validina === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    total++;
    if (!(ok && seen)) begin
      bad++;
      $display("[TB] FAIL mid_first_issue got=0 want=1");
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    total++;
    if ({ready_out, data_validina, nbr0_valid_out, nbr1_valid_out, done_out, err_out} !== '0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs got ready=%0b a=%0b v0=%0b done=%0b want 0",
               ready_out, data_validina, nbr0_valid_out, done_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      if (done_out !== 1'b0 || err_out !== 1'b0 || data_validina !== 1'b0) stray++;
    end
    total++;
    if (stray != 0 || beat_cycles.size() != 0) begin
      bad++;
      $display("[TB] FAIL mid_stray got cycles=%0d beats=%0d want 0 0", stray, beat_cycles.size());
    end
    push_expected(0, 3);
    send_request(0, t_acc, ok);
    wait_done(t_done, ok2);
    total++;
    if (!(ok && ok2) || t_done !== t_acc + 9 || degree_out !== 32'd3 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL mid_recover got ok=%0b dt=%0d deg=%0d left=%0d want ok=1 dt=9 deg=3 left=0",
               ok && ok2, t_done - t_acc, degree_out, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t1, t_done1, t_ready, t_done2;
    bit got_done1, got_ready, ok2;
    logic [31:0] deg1;
    got_done1 = 1'b0; got_ready = 1'b0;
    t_done1 = 0; t_ready = 0; deg1 = '0;
    push_expected(0, 3);
    push_expected(3, 8);
    for (int i = 0; i < 50 && ready_out !== 1'b1; i++) @(negedge clk_in);
    vertex_in = 0;
    vertex_valid_in = 1'b1;
    t1 = cyc;
    @(negedge clk_in);
    vertex_in = 2;
    for (int i = 0; i < 60; i++) begin
      if (done_out === 1'b1 && !got_done1) begin
        got_done1 = 1'b1;
        t_done1 = cyc;
        deg1 = degree_out;
      end
      if (ready_out === 1'b1) begin
        got_ready = 1'b1;
        t_ready = cyc;
        break;
      end
      @(negedge clk_in);
    end
    @(negedge clk_in);
    vertex_valid_in = 1'b0;
    total++;
    if (!(got_done1 && got_ready) || t_done1 !== t1 + 9 || deg1 !== 32'd3 || t_ready !== t_done1 + 1) begin
      bad++;
      $display("[TB] FAIL b2b_first got done_dt=%0d deg=%0d ready_dt=%0d want 9 3 10",
               t_done1 - t1, deg1, t_ready - t1);
    end
    wait_done(t_done2, ok2);
    total++;
    if (!ok2 || t_done2 !== t_ready + 10 || degree_out !== 32'd5 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL b2b_second got ok=%0b dt=%0d deg=%0d left=%0d want ok=1 dt=10 deg=5 left=0",
               ok2, t_done2 - t_ready, degree_out, exp_q.size());
    end
  endtask

  initial begin
    load_rows(0, 3, 3, 8, 16);
    for (int i = 0; i < LAT; i++) begin
      idx_d[i] = '0; a_d[i] = '0; b_d[i] = '0;
    end
    @(negedge clk_in);
    test_reset();
    test_degree3();
    test_degree0();
    test_degree5();
    test_error();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
